// File: rtl/v_mult_accum.sv
// Accumulates a run of unsigned products from a fixed-latency upstream multiplier.
// in_valid is delayed to line up with P; ovf flags any carry out of the accumulator.
module v_mult_accum #(
  parameter int unsigned PW  = 64,
  parameter int unsigned AW  = 72,
  parameter int unsigned LAT = 7,
  parameter int unsigned CW  = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [PW-1:0] P,
  input  logic          start,
  input  logic [CW-1:0] len,
  output logic [AW-1:0] sum,
  output logic          sum_valid,
  output logic          busy,
  output logic          ovf
);

  typedef enum logic [1:0] {StIdle, StAcc, StDone} state_e;

  state_e          state_q, state_d;
  logic [LAT-1:0]  pv_q;
  logic            pv;
  logic [AW-1:0]   acc_q, acc_d;
  logic [AW-1:0]   sum_q, sum_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic [AW:0]     add_res;

  assign pv      = pv_q[LAT-1];
  // One extra bit captures the carry out of the accumulator.
  assign add_res = {1'b0, acc_q} + {{(AW + 1 - PW){1'b0}}, P};

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          acc_d = '0;
          ovf_d = 1'b0;
          cnt_d = len;
          if (len == '0) begin
            sum_d   = '0;
            state_d = StDone;
          end else begin
            state_d = StAcc;
          end
        end
      end
      StAcc: begin
        if (pv) begin
          acc_d = add_res[AW-1:0];
          cnt_d = cnt_q - 1'b1;
          if (add_res[AW]) ovf_d = 1'b1;
          if (cnt_q == CW'(1)) begin
            sum_d   = add_res[AW-1:0];
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      pv_q    <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pv_q[0] <= in_valid;
      for (int i = 1; i < int'(LAT); i++) pv_q[i] <= pv_q[i-1];
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sum       = sum_q;
  assign sum_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_v_mult_accum.sv
// Scoreboard bench: a 72-bit and a 64-bit accumulator share one stimulus stream and a
// behavioural multiplier pipe; expected sums/ovf are pushed at start and popped on sum_valid.
module tb_v_mult_accum;

  localparam int LAT = 7;

  typedef struct {
    logic [71:0] sum72;
    logic [63:0] sum64;
    logic        ovf72;
    logic        ovf64;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  len = '0;
  logic [63:0] opnd = '0;
  logic [63:0] P;
  logic [71:0] sum72;
  logic [63:0] sum64;
  logic        sv72, sv64, busy72, busy64, ovf72, ovf64;

  logic [63:0] mp [LAT] = '{default: '0};
  exp_t        sb [$];
  logic [63:0] vals_q [$];
  int          gaps_q [$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          st_cyc = 0;
  int          sv_cyc = 0;
  int          sv_cnt = 0;
  int          spur_off = 0;
  logic [71:0] hold72 = '0;
  logic [63:0] hold64 = '0;
  logic        prev_sv = 1'b0;

  v_mult_accum u_dut72 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .P(P), .start(start), .len(len),
    .sum(sum72), .sum_valid(sv72), .busy(busy72), .ovf(ovf72)
  );

  v_mult_accum #(.PW(64), .AW(64), .LAT(LAT), .CW(8)) u_dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .P(P), .start(start), .len(len),
    .sum(sum64), .sum_valid(sv64), .busy(busy64), .ovf(ovf64)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    mp[0] <= in_valid ? opnd : 64'h0;
    for (int i = 1; i < LAT; i++) mp[i] <= mp[i-1];
  end
  assign P = mp[LAT-1];

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      hold72  = '0;
      hold64  = '0;
      prev_sv = 1'b0;
    end else begin
      if (prev_sv) begin
        chk("busy_after72", busy72, 0);
        chk("busy_after64", busy64, 0);
      end
      if (sv72 || sv64) begin
        chk("sv72", sv72, 1);
        chk("sv64", sv64, 1);
        chk("sb_nonempty", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("sum72", sum72, e.sum72);
          chk("sum64", sum64, e.sum64);
          chk("ovf72", ovf72, e.ovf72);
          chk("ovf64", ovf64, e.ovf64);
          hold72 = e.sum72;
          hold64 = e.sum64;
        end
        sv_cyc = cyc;
        sv_cnt++;
      end else begin
        chk("hold72", sum72, hold72);
        chk("hold64", sum64, hold64);
      end
      prev_sv = sv72;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives a start that must be ignored, spur_off cycles after the real start.
  task automatic tick_s();
    tick();
    start = (spur_off > 0) && (cyc - st_cyc == spur_off);
    if (start) len = 8'd5;
  endtask

  task automatic do_acc(input int n, input bit dn_pv);
    exp_t        e;
    logic [72:0] s72;
    logic [64:0] s64;
    e.ovf72 = 1'b0;
    e.ovf64 = 1'b0;
    s72 = '0;
    s64 = '0;
    for (int i = 0; i < n; i++) begin
      s72 = {1'b0, s72[71:0]} + {9'h0, vals_q[i]};
      s64 = {1'b0, s64[63:0]} + {1'b0, vals_q[i]};
      e.ovf72 = e.ovf72 | s72[72];
      e.ovf64 = e.ovf64 | s64[64];
    end
    e.sum72 = s72[71:0];
    e.sum64 = s64[63:0];
    sb.push_back(e);
    start  = 1'b1;
    len    = 8'(n);
    st_cyc = cyc;
    tick_s();
    start = 1'b0;
    chk("busy_run", busy72, 1);
    chk("ovf_clr72", ovf72, 0);
    chk("ovf_clr64", ovf64, 0);
    for (int i = 0; i < n; i++) begin
      repeat (gaps_q[i]) tick_s();
      in_valid = 1'b1;
      opnd     = vals_q[i];
      tick_s();
      in_valid = 1'b0;
    end
    // This product lands while the block sits in DONE and must not count.
    if (dn_pv && n > 0) begin
      in_valid = 1'b1;
      opnd     = {$urandom, $urandom};
      tick();
      in_valid = 1'b0;
    end
    repeat (LAT + 3) tick_s();
    chk("sb_drain", sb.size(), 0);
    chk("ovf_hold72", ovf72, e.ovf72);
    chk("ovf_hold64", ovf64, e.ovf64);
    spur_off = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt0;
    #2 rst = 1'b1;
    #1;
    chk("rst_sum72", sum72, 0);
    chk("rst_sum64", sum64, 0);
    chk("rst_sv", {sv72, sv64}, 0);
    chk("rst_busy", {busy72, busy64}, 0);
    chk("rst_ovf", {ovf72, ovf64}, 0);
    tick();
    tick();
    rst = 1'b0;

    // Basic sum: 5 + 7 + 11 with back-to-back operands.
    vals_q = '{64'd5, 64'd7, 64'd11};
    gaps_q = '{0, 0, 0};
    do_acc(3, 1'b0);
    chk("lat_basic", sv_cyc - st_cyc, 11);

    // Zero length.
    do_acc(0, 1'b0);
    chk("lat_zero", sv_cyc - st_cyc, 1);

    // Overflow only in the 64-bit instance.
    vals_q = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd2};
    gaps_q = '{0, 0};
    do_acc(2, 1'b0);
    repeat (3) tick();
    chk("ovf_sticky64", ovf64, 1);

    // Gaps and an ignored start at cycle 12; pv at 9 and 15.
    vals_q   = '{64'd100, 64'd23};
    gaps_q   = '{1, 5};
    spur_off = 12;
    cnt0     = sv_cnt;
    do_acc(2, 1'b0);
    chk("lat_gap", sv_cyc - st_cyc, 16);
    chk("gap_pulses", sv_cnt - cnt0, 1);

    // A product arriving in IDLE must not disturb anything.
    in_valid = 1'b1;
    opnd     = 64'd1000;
    tick();
    in_valid = 1'b0;
    repeat (LAT + 2) tick();
    chk("idle_pv_busy", busy72, 0);

    // Reset after one of four products has been accumulated.
    start  = 1'b1;
    len    = 8'd4;
    st_cyc = cyc;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      opnd     = 64'(i + 50);
      tick();
    end
    in_valid = 1'b0;
    while (cyc - st_cyc < 9) tick();
    #2 rst = 1'b1;
    #1;
    chk("mid_sum", {sum72, sum64}, 0);
    chk("mid_flags", {sv72, sv64, busy72, busy64, ovf72, ovf64}, 0);
    tick();
    tick();
    rst = 1'b0;
    vals_q = '{64'd9};
    gaps_q = '{0};
    do_acc(1, 1'b0);

    // Random regression.
    for (int r = 0; r < 24; r++) begin
      int n;
      n = $urandom_range(0, 6);
      vals_q.delete();
      gaps_q.delete();
      for (int i = 0; i < n; i++) begin
        vals_q.push_back(($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF
                                                      : {$urandom, $urandom});
        gaps_q.push_back($urandom_range(0, 3));
      end
      spur_off = (n > 0 && $urandom_range(0, 1) == 1) ? $urandom_range(2, LAT + 1) : 0;
      do_acc(n, $urandom_range(0, 1) == 1);
      if ($urandom_range(0, 2) == 0) begin
        in_valid = 1'b1;
        opnd     = {$urandom, $urandom};
        tick();
        in_valid = 1'b0;
        repeat (LAT + 2) tick();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/v_mult_accum.md
V_MULT_ACCUM -- requirements
Module: v_mult_accum

Interface
REQ-001 The block SHALL have parameter PW, default 64, giving the width of the product input from the upstream unsigned 32x32 multiplier.
REQ-002 The block SHALL have parameter AW, default 72, giving the accumulator and sum width; AW >= PW.
REQ-003 The block SHALL have parameter LAT, default 7, giving the operand-to-product latency of the upstream multiplier in clock cycles; LAT >= 1.
REQ-004 The block SHALL have parameter CW, default 8, giving the width of the product-count input.
REQ-005 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 Port in_valid, input, 1 bit: high in the same cycle the operand pair is presented to the upstream multiplier.
REQ-008 Port P, input, PW bits: unsigned product from the upstream multiplier.
REQ-009 Port start, input, 1 bit: request to begin a new accumulation.
REQ-010 Port len, input, CW bits: number of products to accumulate, sampled when start is accepted.
REQ-011 Port sum, output, AW bits: accumulated result, registered.
REQ-012 Port sum_valid, output, 1 bit: one-cycle pulse marking sum valid.
REQ-013 Port busy, output, 1 bit: high while state is not IDLE.
REQ-014 Port ovf, output, 1 bit: sticky accumulator-overflow flag for the current or last accumulation.

Function
REQ-015 The block SHALL delay in_valid through exactly LAT register stages to form pv, so that pv is high in the cycle the matching product is on P.
REQ-016 The block SHALL implement the states IDLE, ACC and DONE.
REQ-017 In IDLE with start=1 and len!=0, the block SHALL clear acc to 0, clear ovf, load the remaining-count register with len, and enter ACC on the next edge.
REQ-018 In IDLE with start=1 and len=0, the block SHALL clear acc and ovf and enter DONE on the next edge, giving sum=0.
REQ-019 In ACC, each cycle with pv=1 SHALL add zero-extended P to acc and decrement the remaining count by one.
REQ-020 When a pv=1 cycle in ACC decrements the remaining count to 0, the block SHALL enter DONE on the next edge, with sum equal to the final acc.
REQ-021 DONE SHALL last exactly one cycle, with sum_valid=1; the block SHALL then return to IDLE.
REQ-022 sum SHALL hold its value outside DONE until the next DONE.
REQ-023 acc SHALL wrap modulo 2^AW.
REQ-024 Any carry out of bit AW-1 during an addition SHALL set ovf, which SHALL stay set until the next accepted start.
REQ-025 pv=1 while in IDLE or DONE SHALL be ignored: no accumulation and no count change.
REQ-026 start while in ACC or DONE SHALL be ignored, and len SHALL not be resampled.
REQ-027 In the cycle start is accepted in IDLE, a coincident pv SHALL be ignored.
REQ-028 The delay line SHALL keep shifting in every state, so in_valid issued during any state is aligned correctly.
REQ-029 Total latency SHALL be one cycle from the last accumulating pv to sum_valid.

Reset
REQ-030 On rst=1, asynchronously and independent of clk, the block SHALL set state=IDLE, all pv delay stages=0, acc=0, count=0, sum=0, sum_valid=0, busy=0 and ovf=0.
REQ-031 A reset asserted mid-accumulation SHALL abandon that accumulation with no sum_valid pulse, and products already in flight SHALL be discarded.
REQ-032 After rst deasserts, the block SHALL accept start on the first rising edge.

Verification
REQ-033 Basic sum: start with len=3 at cycle 0; in_valid at cycles 1, 2, 3 with products 5, 7, 11 appearing at cycles 8, 9, 10 -> sum=23 and sum_valid=1 at cycle 11, busy low from cycle 12.
REQ-034 Zero length: start with len=0 -> sum=0 and sum_valid=1 one cycle after start, ovf=0.
REQ-035 Overflow with AW=PW=64: len=2, products 0xFFFF_FFFF_FFFF_FFFF and 2 -> sum=1, ovf=1; ovf stays 1 until the next start is accepted, then clears.
REQ-036 Gaps and ignores: len=2 with pv at cycles 9 and 15 and a start pulse at cycle 12 -> single sum_valid at cycle 16 and the start at cycle 12 is ignored; a pv arriving in IDLE leaves acc unchanged.
REQ-037 Mid-operation reset: rst pulse after one of four products -> all outputs 0, no sum_valid; a later start with len=1 and product 9 gives sum=9.
REQ-038 Random regression: random len, gaps and products compared against a reference model of the modulo-2^AW sum and ovf.
